// File: rtl/ir_beacon_tx.sv
// IR beacon transmitter: takes a 3-bit frequency code and drives a square-wave
// burst of that code's frequency on ir_led, then a dark gap.
module ir_beacon_tx #(
  parameter int HALF_R_B      = 250000,
  parameter int HALF_R_G      = 50000,
  parameter int HALF_B_G      = 10000,
  parameter int HALF_STOP     = 7142,
  parameter int BURST_PERIODS = 20,
  parameter int GAP_CLKS      = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] cmd,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       abort,
  output logic       ir_led,
  output logic [2:0] active_code,
  output logic       cmd_done,
  output logic       cmd_err
);

  localparam int PW = $clog2(BURST_PERIODS + 1);
  localparam int GW = $clog2(GAP_CLKS + 1);

  localparam logic [19:0]   LOAD_R_B   = 20'(HALF_R_B - 1);
  localparam logic [19:0]   LOAD_R_G   = 20'(HALF_R_G - 1);
  localparam logic [19:0]   LOAD_B_G   = 20'(HALF_B_G - 1);
  localparam logic [19:0]   LOAD_STOP  = 20'(HALF_STOP - 1);
  localparam logic [PW-1:0] BURST_LAST = PW'(BURST_PERIODS);
  localparam logic [GW-1:0] GAP_LOAD   = GW'(GAP_CLKS - 1);

  typedef enum logic [1:0] {IDLE, MARK, SPACE, GAP} state_t;

  state_t        state_q, state_d;
  logic [19:0]   half_q, half_d;
  logic [PW-1:0] period_q, period_d;
  logic [PW-1:0] period_inc;
  logic [GW-1:0] gap_q, gap_d;
  logic [2:0]    code_q, code_d;
  logic          led_q, led_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          accept;
  logic          code_ok;

  function automatic logic [19:0] half_load(input logic [2:0] code);
    case (code)
      3'd1:    half_load = LOAD_R_B;
      3'd2:    half_load = LOAD_R_G;
      3'd3:    half_load = LOAD_B_G;
      3'd4:    half_load = LOAD_STOP;
      default: half_load = '0;
    endcase
  endfunction

  assign accept     = cmd_valid && cmd_ready;
  assign code_ok    = (cmd != 3'd0) && (cmd <= 3'd4);
  assign period_inc = period_q + PW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      half_q   <= '0;
      period_q <= '0;
      gap_q    <= '0;
      code_q   <= '0;
      led_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      half_q   <= half_d;
      period_q <= period_d;
      gap_q    <= gap_d;
      code_q   <= code_d;
      led_q    <= led_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Abort from any busy state returns to IDLE with every counter cleared.
  always_comb begin
    state_d  = state_q;
    half_d   = half_q;
    period_d = period_q;
    gap_d    = gap_q;
    code_d   = code_q;
    case (state_q)
      IDLE: begin
        if (accept && code_ok) begin
          state_d  = MARK;
          code_d   = cmd;
          half_d   = half_load(cmd);
          period_d = '0;
        end
      end
      MARK: begin
        if (half_q == 20'd0) begin
          state_d = SPACE;
          half_d  = half_load(code_q);
        end else begin
          half_d = half_q - 20'd1;
        end
      end
      SPACE: begin
        if (half_q == 20'd0) begin
          period_d = period_inc;
          if (period_inc == BURST_LAST) begin
            state_d = GAP;
            gap_d   = GAP_LOAD;
          end else begin
            state_d = MARK;
            half_d  = half_load(code_q);
          end
        end else begin
          half_d = half_q - 20'd1;
        end
      end
      GAP: begin
        if (gap_q == '0) begin
          state_d  = IDLE;
          code_d   = '0;
          period_d = '0;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort && (state_q != IDLE)) begin
      state_d  = IDLE;
      half_d   = '0;
      period_d = '0;
      gap_d    = '0;
      code_d   = '0;
    end
  end

  always_comb begin
    cmd_ready   = (state_q == IDLE) && !abort;
    active_code = (state_q == IDLE) ? 3'd0 : code_q;
    led_d       = (state_d == MARK);
    done_d      = (state_q == GAP) && (gap_q == '0) && !abort;
    err_d       = accept && !code_ok;
  end

  assign ir_led   = led_q;
  assign cmd_done = done_q;
  assign cmd_err  = err_q;

endmodule

// File: tb/tb_ir_beacon_tx.sv
// Directed bench for ir_beacon_tx using small half-periods so whole bursts
// can be checked cycle by cycle against hand-derived waveforms.
module tb_ir_beacon_tx;

  localparam int HALF_R_B      = 4;
  localparam int HALF_R_G      = 3;
  localparam int HALF_B_G      = 2;
  localparam int HALF_STOP     = 1;
  localparam int BURST_PERIODS = 3;
  localparam int GAP_CLKS      = 5;

  logic       clk;
  logic       rstN;
  logic [2:0] cmd;
  logic       cmdValid;
  logic       cmdReady;
  logic       abort;
  logic       irLed;
  logic [2:0] activeCode;
  logic       cmdDone;
  logic       cmdErr;

  int checkCount;
  int errorCount;

  ir_beacon_tx #(
    .HALF_R_B(HALF_R_B), .HALF_R_G(HALF_R_G), .HALF_B_G(HALF_B_G),
    .HALF_STOP(HALF_STOP), .BURST_PERIODS(BURST_PERIODS), .GAP_CLKS(GAP_CLKS)
  ) dut (
    .clk(clk),
    .rst_n(rstN),
    .cmd(cmd),
    .cmd_valid(cmdValid),
    .cmd_ready(cmdReady),
    .abort(abort),
    .ir_led(irLed),
    .active_code(activeCode),
    .cmd_done(cmdDone),
    .cmd_err(cmdErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] c, input logic v, input logic a);
    cmd      = c;
    cmdValid = v;
    abort    = a;
  endtask

  // Called just after a negedge; accept happens at the next posedge (edge 0).
  task automatic runBurst(input logic [2:0] code, input int half, input bit holdValid, input logic [2:0] holdCode);
    int burstLen;
    int doneCycle;
    logic expLed;
    burstLen  = 2 * half * BURST_PERIODS;
    doneCycle = 1 + burstLen + GAP_CLKS;
    applyStimulus(code, 1'b1, 1'b0);
    for (int c = 1; c <= doneCycle; c++) begin
      @(negedge clk);
      expLed = (c <= burstLen) && ((((c - 1) / half) % 2) == 0);
      checkOutput($sformatf("code%0d led c%0d", code, c), irLed, expLed);
      checkOutput($sformatf("code%0d active c%0d", code, c), activeCode, (c < doneCycle) ? code : 3'd0);
      checkOutput($sformatf("code%0d done c%0d", code, c), cmdDone, c == doneCycle);
      checkOutput($sformatf("code%0d ready c%0d", code, c), cmdReady, c == doneCycle);
      checkOutput($sformatf("code%0d err c%0d", code, c), cmdErr, 1'b0);
      if (c == 1) begin
        if (holdValid) applyStimulus(holdCode, 1'b1, 1'b0);
        else applyStimulus(3'd0, 1'b0, 1'b0);
      end
    end
    applyStimulus(3'd0, 1'b0, 1'b0);
  endtask

  initial begin
    logic sawDone;
    checkCount = 0;
    errorCount = 0;
    rstN = 1'b0;
    applyStimulus(3'd0, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    checkOutput("reset led", irLed, 1'b0);
    checkOutput("reset active", activeCode, 3'd0);
    checkOutput("reset done", cmdDone, 1'b0);
    checkOutput("reset err", cmdErr, 1'b0);
    rstN = 1'b1;
    @(negedge clk);
    checkOutput("post-reset ready", cmdReady, 1'b1);

    $display("[TB] code 1 full burst");
    runBurst(3'd1, HALF_R_B, 1'b0, 3'd0);

    $display("[TB] code 4 full burst");
    runBurst(3'd4, HALF_STOP, 1'b0, 3'd0);

    $display("[TB] invalid codes");
    applyStimulus(3'd0, 1'b1, 1'b0);
    #1 checkOutput("inv ready before", cmdReady, 1'b1);
    @(negedge clk);
    checkOutput("inv0 err", cmdErr, 1'b1);
    checkOutput("inv0 led", irLed, 1'b0);
    checkOutput("inv0 ready", cmdReady, 1'b1);
    applyStimulus(3'd5, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("inv5 err", cmdErr, 1'b1);
    checkOutput("inv5 led", irLed, 1'b0);
    checkOutput("inv5 active", activeCode, 3'd0);
    applyStimulus(3'd0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("inv err clears", cmdErr, 1'b0);
    checkOutput("inv no done", cmdDone, 1'b0);
    checkOutput("inv ready after", cmdReady, 1'b1);

    $display("[TB] busy requests ignored, back-to-back accept");
    runBurst(3'd2, HALF_R_G, 1'b1, 3'd1);
    runBurst(3'd3, HALF_B_G, 1'b0, 3'd0);

    $display("[TB] abort in second SPACE");
    applyStimulus(3'd1, 1'b1, 1'b0);
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      checkOutput($sformatf("abort led c%0d", c), irLed, (c <= 4) || (c >= 9 && c <= 12));
      if (c == 1) applyStimulus(3'd0, 1'b0, 1'b0);
      if (c == 14) applyStimulus(3'd0, 1'b0, 1'b1);
    end
    @(negedge clk);
    checkOutput("abort led after", irLed, 1'b0);
    checkOutput("abort active after", activeCode, 3'd0);
    applyStimulus(3'd0, 1'b0, 1'b0);
    #1 checkOutput("abort ready after", cmdReady, 1'b1);
    sawDone = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      sawDone = sawDone | cmdDone;
    end
    checkOutput("abort no done", sawDone, 1'b0);

    applyStimulus(3'd1, 1'b1, 1'b1);
    #1 checkOutput("idle abort blocks ready", cmdReady, 1'b0);
    @(negedge clk);
    checkOutput("idle abort no accept led", irLed, 1'b0);
    checkOutput("idle abort no accept active", activeCode, 3'd0);
    checkOutput("idle abort no err", cmdErr, 1'b0);
    applyStimulus(3'd0, 1'b0, 1'b0);

    $display("[TB] async reset mid-MARK");
    applyStimulus(3'd1, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(3'd0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("mark before reset led", irLed, 1'b1);
    #2 rstN = 1'b0;
    #1 checkOutput("async reset led", irLed, 1'b0);
    checkOutput("async reset active", activeCode, 3'd0);
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    checkOutput("release ready", cmdReady, 1'b1);
    checkOutput("release led", irLed, 1'b0);
    checkOutput("release active", activeCode, 3'd0);
    checkOutput("release done", cmdDone, 1'b0);
    checkOutput("release err", cmdErr, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
